// File: rtl/mem_scan_pkg.sv
// Shared types and defaults for the memory scan reader.
// The checksum output is enabled with MEM_SCAN_CHECKSUM_EN.
package mem_scan_pkg;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_DWELL   = 500;
    localparam int RAM_LATENCY = 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4,
        S_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/mem_scan_reader_dwell_timer.sv
// Loadable down-counter that paces how long each word stays on the display.
// A load takes precedence over a decrement.
module dwell_timer #(
    parameter int CNT_W = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Count register: load, decrement when enabled, otherwise hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != {CNT_W{1'b0}})) begin
            r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_scan_reader.sv
// Scans RAM from address 0 to a programmed last address and holds each word for display.
// Define MEM_SCAN_CHECKSUM_EN to add a running checksum of the captured words.
module mem_scan_reader
    import mem_scan_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DWELL  = DEF_DWELL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              auto,
    input  logic              step,
    input  logic              abort,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              busy,
`ifdef MEM_SCAN_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              done
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

    state_e            r_state;
    state_e            w_next;
    logic              w_advance;
    logic              w_start_acc;
    logic              w_zero;
    logic              w_load;
    logic              w_en;
    logic [ADDR_W-1:0] r_lim;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_re;
    logic [ADDR_W-1:0] r_disp_addr;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_busy;
    logic              r_done;

    // The counter is reloaded on every capture and only runs in HOLD with auto set,
    // so dropping auto freezes it and the remaining dwell resumes later.
    assign w_load = (r_state == S_CAPTURE);
    assign w_en   = (r_state == S_HOLD) && auto && !abort;

    dwell_timer #(.CNT_W(CNT_W)) u_dwell (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_load_val (DWELL_LOAD),
        .i_en       (w_en),
        .o_zero     (w_zero)
    );

    // Next-state logic; abort overrides every other request.
    always_comb begin
        w_next      = r_state;
        w_advance   = 1'b0;
        w_start_acc = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        w_start_acc = 1'b1;
                        w_next      = S_ISSUE;
                    end else begin
                        w_next = r_state;
                    end
                end
                S_ISSUE:   w_next = S_WAIT;
                S_WAIT:    w_next = S_CAPTURE;
                S_CAPTURE: w_next = S_HOLD;
                S_HOLD: begin
                    if (auto) begin
                        w_advance = w_zero;
                    end else begin
                        w_advance = step;
                    end
                    if (!w_advance) begin
                        w_next = S_HOLD;
                    end else if (r_ram_addr == r_lim) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_ISSUE;
                    end
                end
                default:   w_next = S_IDLE;
            endcase
        end
    end

    // State, address and display registers; control outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lim       <= {ADDR_W{1'b0}};
            r_ram_addr  <= {ADDR_W{1'b0}};
            r_ram_re    <= 1'b0;
            r_disp_addr <= {ADDR_W{1'b0}};
            r_disp_data <= {DATA_W{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_ram_re <= (w_next == S_ISSUE);
            r_busy   <= (w_next != S_IDLE) && (w_next != S_DONE);
            r_done   <= (w_next == S_DONE);
            if (w_start_acc) begin
                r_lim      <= last_addr;
                r_ram_addr <= {ADDR_W{1'b0}};
            end else if (w_advance && (r_ram_addr != r_lim)) begin
                r_ram_addr <= r_ram_addr + ADDR_W'(1);
            end else begin
                r_ram_addr <= r_ram_addr;
            end
            if ((r_state == S_CAPTURE) && !abort) begin
                r_disp_addr <= r_ram_addr;
                r_disp_data <= ram_dout;
            end else begin
                r_disp_data <= r_disp_data;
            end
        end
    end

`ifdef MEM_SCAN_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // Running modulo-2^DATA_W sum of every captured word in the current scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= {DATA_W{1'b0}};
        end else if (w_start_acc) begin
            r_checksum <= {DATA_W{1'b0}};
        end else if ((r_state == S_CAPTURE) && !abort) begin
            r_checksum <= r_checksum + ram_dout;
        end else begin
            r_checksum <= r_checksum;
        end
    end

    assign checksum = r_checksum;
`endif

    assign ram_addr  = r_ram_addr;
    assign ram_re    = r_ram_re;
    assign disp_addr = r_disp_addr;
    assign disp_data = r_disp_data;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
